trap_filter_ctrl: RTL

- Sequencer and configuration controller for the runtime-configurable trapezoidal shaping filter (k/l/M pipeline with two running accumulators).
- Owns the filter's parameters and its active-low reset. Accepts new k/l/M through a valid/ready handshake and flushes the filter accumulators.
- Suppresses output until the delay line and pipeline have settled, then forwards filtered samples with a valid strobe aligned to the input stream.

---
 rtl/trap_filter_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/trap_filter_ctrl.sv
// trap_filter_ctrl: sequencer and configuration controller for the trapezoidal shaping filter
// Owns the filter's k/l/M parameters and active-low reset. It flushes the filter and then
// waits for it to settle. After that it forwards filtered samples with a valid strobe.
// Optional feature macro: TRAP_FILTER_CTRL_AUTOFLUSH_EN flushes after IDLE_TIMEOUT idle cycles in RUN.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   cfg_valid/cfg_ready/cfg_err configuration handshake and reject pulse
//   cfg_k, cfg_l, cfg_m         requested filter parameters
//   flush_req                   single-cycle flush request
//   in_valid, in_data           input sample stream
//   filt_rst_n, filt_k/l/m      filter reset and applied parameters
//   filt_in_data, filt_out_data filter data in and out
//   out_valid, out_data         registered filtered output
//   busy                        high while flushing or settling
module trap_filter_ctrl #(
  parameter int SIZE_FILTER_DATA = 16,
  parameter int K_MAX = 64,
  parameter int M_W = 4,
  parameter int K_DEF = 8,
  parameter int L_DEF = 4,
  parameter int M_DEF = 5,
  parameter int PIPE_LAT = 6,
  parameter int FLUSH_CYC = 2,
  parameter int IDLE_TIMEOUT = 256
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [6:0]                  cfg_k,
  input  logic [6:0]                  cfg_l,
  input  logic [M_W-1:0]              cfg_m,
  output logic                        cfg_err,
  input  logic                        flush_req,
  input  logic                        in_valid,
  input  logic [SIZE_FILTER_DATA-1:0] in_data,
  output logic                        filt_rst_n,
  output logic [6:0]                  filt_k,
  output logic [6:0]                  filt_l,
  output logic [M_W-1:0]              filt_m,
  output logic [SIZE_FILTER_DATA-1:0] filt_in_data,
  input  logic [SIZE_FILTER_DATA-1:0] filt_out_data,
  output logic                        out_valid,
  output logic [SIZE_FILTER_DATA-1:0] out_data,
  output logic                        busy
);
  typedef enum logic [1:0] {FLUSH, SETTLE, RUN} state_t;
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d, settle_len;
  logic [6:0] filt_k_q, filt_k_d, filt_l_q, filt_l_d;
  logic [M_W-1:0] filt_m_q, filt_m_d;
  logic [SIZE_FILTER_DATA-1:0] filt_in_data_q, filt_in_data_d, out_data_q, out_data_d;
  logic [PIPE_LAT:0] vpipe_q, vpipe_d;
  logic filt_rst_n_q, filt_rst_n_d, cfg_ready_q, cfg_ready_d, cfg_err_q, cfg_err_d;
  logic busy_q, busy_d, out_valid_q, out_valid_d;
  logic run, acc, cfg_ok, apply, auto_flush;
`ifdef TRAP_FILTER_CTRL_AUTOFLUSH_EN
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  logic [IW-1:0] idle_q, idle_d;
  assign auto_flush = run && !in_valid && idle_q == IW'(IDLE_TIMEOUT - 1);
  always_comb idle_d = (state_d == RUN && !in_valid) ? idle_q + IW'(1) : '0;
  always_ff @(posedge clk) idle_q <= reset ? '0 : idle_d;
`else
  localparam int unused_idle_timeout = IDLE_TIMEOUT;
  assign auto_flush = 1'b0;
`endif
  always_comb begin
    run = state_q == RUN;
    acc = cfg_valid && cfg_ready_q;
    cfg_ok = cfg_l != 7'd0 && cfg_l <= cfg_k && cfg_k <= 7'(K_MAX);
    apply = acc && cfg_ok;
    settle_len = 8'(filt_k_q) + 8'(filt_l_q) + 8'(PIPE_LAT);
    cnt_d = run ? 8'd0 : cnt_q + 8'd1;
    state_d = state_q;
    if (state_q == FLUSH && cnt_q == 8'(FLUSH_CYC - 1)) begin
      state_d = SETTLE;
      cnt_d = '0;
    end
    // SETTLE lasts exactly settle_len cycles
    if (state_q == SETTLE && cnt_d == settle_len) begin
      state_d = RUN;
      cnt_d = '0;
    end
    if (flush_req || apply || auto_flush) begin
      state_d = FLUSH;
      cnt_d = '0;
    end
    // parameters only move on the edge that enters FLUSH
    filt_k_d = apply ? cfg_k : filt_k_q;
    filt_l_d = apply ? cfg_l : filt_l_q;
    filt_m_d = apply ? cfg_m : filt_m_q;
    filt_rst_n_d = state_d != FLUSH;
    cfg_ready_d = state_d == RUN;
    busy_d = state_d != RUN;
    cfg_err_d = acc && !cfg_ok;
    filt_in_data_d = (state_d != FLUSH && in_valid) ? in_data : '0;
    // only samples admitted while running may ever raise out_valid
    vpipe_d = {vpipe_q[PIPE_LAT-1:0], in_valid && run};
    out_valid_d = vpipe_q[PIPE_LAT] && state_d == RUN;
    out_data_d = filt_out_data;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FLUSH;
      cnt_q <= '0;
      filt_k_q <= 7'(K_DEF);
      filt_l_q <= 7'(L_DEF);
      filt_m_q <= M_W'(M_DEF);
      filt_rst_n_q <= 1'b0;
      cfg_ready_q <= 1'b0;
      cfg_err_q <= 1'b0;
      busy_q <= 1'b1;
      filt_in_data_q <= '0;
      vpipe_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      filt_k_q <= filt_k_d;
      filt_l_q <= filt_l_d;
      filt_m_q <= filt_m_d;
      filt_rst_n_q <= filt_rst_n_d;
      cfg_ready_q <= cfg_ready_d;
      cfg_err_q <= cfg_err_d;
      busy_q <= busy_d;
      filt_in_data_q <= filt_in_data_d;
      vpipe_q <= vpipe_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
    end
  end
  assign cfg_ready = cfg_ready_q;
  assign cfg_err = cfg_err_q;
  assign filt_rst_n = filt_rst_n_q;
  assign filt_k = filt_k_q;
  assign filt_l = filt_l_q;
  assign filt_m = filt_m_q;
  assign filt_in_data = filt_in_data_q;
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign busy = busy_q;
endmodule
